instr_mem_mp: RTL and testbench

Multi-port instruction memory for the processor array. Each core gets its own registered read channel, and all channels share a single storage array. Storage is written through either a random-access write port or a streaming program loader with an auto-incrementing pointer. It replaces the single-port instruction memory and adds per-channel reads, write-to-read bypass and sequential program download.

---
 rtl/instr_mem_mp.sv | 99 +++++++++
 tb/tb_instr_mem_mp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_mp.sv
// Multi-port instruction memory: per-channel registered reads over one shared array,
// written by a random-access port or a streaming loader with an auto-incrementing pointer.
module instr_mem_mp #(
    parameter int unsigned INSTR_WIDTH = 8,
    parameter int unsigned PC_WIDTH    = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned READ_PORTS  = 2,
    parameter bit          BYPASS      = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [READ_PORTS*PC_WIDTH-1:0]    raddr,
    output logic [READ_PORTS*INSTR_WIDTH-1:0] rdata,
    input  logic                              we,
    input  logic [PC_WIDTH-1:0]               waddr,
    input  logic [INSTR_WIDTH-1:0]            wdata,
    input  logic                              load_start,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [INSTR_WIDTH-1:0]            load_data,
    output logic [PC_WIDTH-1:0]               load_ptr,
    output logic                              load_wrap
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [INSTR_WIDTH-1:0]            mem_q [DEPTH];
    logic [READ_PORTS*INSTR_WIDTH-1:0] rdata_q, rdata_d;
    logic [PC_WIDTH-1:0]               load_ptr_q, load_ptr_d;
    logic                              load_wrap_q;

    logic                   port_wr, load_xfer, wr_en, ptr_last;
    logic [AW-1:0]          wr_idx;
    logic [INSTR_WIDTH-1:0] wr_data;

    // Write port wins; the loader only moves when the port is idle.
    assign load_ready = ~we & ~rst;
    assign port_wr    = we && (32'(waddr) < DEPTH);
    assign load_xfer  = load_valid && load_ready;
    assign wr_en      = port_wr || load_xfer;
    assign ptr_last   = (32'(load_ptr_q) == DEPTH - 1);

    always_comb begin
        wr_idx  = load_ptr_q[AW-1:0];
        wr_data = load_data;
        if (we) begin
            wr_idx  = waddr[AW-1:0];
            wr_data = wdata;
        end
    end

    always_comb begin
        load_ptr_d = load_ptr_q;
        if (load_start) begin
            load_ptr_d = '0;
        end else if (load_xfer) begin
            load_ptr_d = ptr_last ? '0 : load_ptr_q + PC_WIDTH'(1);
        end
    end

    always_comb begin
        logic [PC_WIDTH-1:0] ra;
        ra      = '0;
        rdata_d = '0;
        for (int k = 0; k < READ_PORTS; k++) begin
            ra = raddr[k*PC_WIDTH +: PC_WIDTH];
            if (32'(ra) < DEPTH) begin
                if (BYPASS && wr_en && (wr_idx == ra[AW-1:0])) begin
                    rdata_d[k*INSTR_WIDTH +: INSTR_WIDTH] = wr_data;
                end else begin
                    rdata_d[k*INSTR_WIDTH +: INSTR_WIDTH] = mem_q[ra[AW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q     <= '0;
            load_ptr_q  <= '0;
            load_wrap_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_idx] <= wr_data;
            end
            rdata_q     <= rdata_d;
            load_ptr_q  <= load_ptr_d;
            load_wrap_q <= load_xfer && ptr_last;
        end
    end

    assign rdata     = rdata_q;
    assign load_ptr  = load_ptr_q;
    assign load_wrap = load_wrap_q;

endmodule

// File: tb/tb_instr_mem_mp.sv
// Scoreboard bench: two instances (16-deep with bypass, 12-deep without) share stimulus.
module tb_instr_mem_mp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] raddr = '0;
    logic       we = 1'b0;
    logic [3:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;

    logic [15:0] rdata_a, rdata_b;
    logic        load_ready_a, load_ready_b;
    logic [3:0]  load_ptr_a, load_ptr_b;
    logic        load_wrap_a, load_wrap_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a0, a1, b0, b1;
    } exp_t;
    exp_t sb[$];
    logic chk = 1'b0;
    logic chk_d = 1'b0;

    always #5 clk = ~clk;

    instr_mem_mp #(.INSTR_WIDTH(8), .PC_WIDTH(4), .DEPTH(16), .READ_PORTS(2), .BYPASS(1'b1)) u_a (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_a), .we(we), .waddr(waddr),
        .wdata(wdata), .load_start(load_start), .load_valid(load_valid),
        .load_ready(load_ready_a), .load_data(load_data), .load_ptr(load_ptr_a),
        .load_wrap(load_wrap_a)
    );

    instr_mem_mp #(.INSTR_WIDTH(8), .PC_WIDTH(4), .DEPTH(12), .READ_PORTS(2), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .we(we), .waddr(waddr),
        .wdata(wdata), .load_start(load_start), .load_valid(load_valid),
        .load_ready(load_ready_b), .load_data(load_data), .load_ptr(load_ptr_b),
        .load_wrap(load_wrap_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [3:0] r0, input logic [3:0] r1, input logic [7:0] ea0,
                      input logic [7:0] ea1, input logic [7:0] eb0, input logic [7:0] eb1);
        exp_t e;
        e.a0 = ea0; e.a1 = ea1; e.b0 = eb0; e.b1 = eb1;
        raddr = {r1, r0};
        chk   = 1'b1;
        sb.push_back(e);
        cyc();
        chk = 1'b0;
    endtask

    // Expected contents after the 17-word stream 01..11.
    function automatic logic [7:0] ld_a(input int x);
        return (x == 0) ? 8'h11 : 8'(x + 1);
    endfunction

    function automatic logic [7:0] ld_b(input int x);
        if (x >= 12) return 8'h00;
        return (x <= 4) ? 8'(x + 13) : 8'(x + 1);
    endfunction

    always @(posedge clk) chk_d <= chk;

    always @(negedge clk) begin
        if (chk_d) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got output with empty queue expected entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata_a0", 32'(rdata_a[7:0]), 32'(e.a0));
                check("rdata_a1", 32'(rdata_a[15:8]), 32'(e.a1));
                check("rdata_b0", 32'(rdata_b[7:0]), 32'(e.b0));
                check("rdata_b1", 32'(rdata_b[15:8]), 32'(e.b1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1;
        check("rst_rdata_a", 32'(rdata_a), 0);
        check("rst_rdata_b", 32'(rdata_b), 0);
        check("rst_ptr_a", 32'(load_ptr_a), 0);
        check("rst_wrap_a", 32'(load_wrap_a), 0);
        check("rst_ready_a", 32'(load_ready_a), 0);
        cyc();
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i), 8'h00, 8'h00, 8'h00, 8'h00);

        // Random-access write, then out-of-range write on the 12-deep instance.
        we = 1'b1; waddr = 4'd5; wdata = 8'hA5;
        cyc();
        we = 1'b0;
        rd(4'd5, 4'd5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
        we = 1'b1; waddr = 4'd15; wdata = 8'h5A;
        cyc();
        we = 1'b0;
        rd(4'd15, 4'd3, 8'h5A, 8'h00, 8'h00, 8'h00);

        // Same-cycle write/read: forwarded on u_a, old data on u_b.
        we = 1'b1; waddr = 4'd2; wdata = 8'h11;
        cyc();
        wdata = 8'h22;
        rd(4'd2, 4'd2, 8'h22, 8'h22, 8'h11, 8'h11);
        we = 1'b0;
        rd(4'd2, 4'd2, 8'h22, 8'h22, 8'h22, 8'h22);

        // Loader stream with wrap.
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        check("ptr_after_start", 32'(load_ptr_a), 0);
        load_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            load_data = 8'(i);
            cyc();
            check("ld_ptr_a", 32'(load_ptr_a), 32'(i % 16));
            check("ld_wrap_a", 32'(load_wrap_a), (i == 16) ? 1 : 0);
            check("ld_ptr_b", 32'(load_ptr_b), 32'(i % 12));
            check("ld_wrap_b", 32'(load_wrap_b), (i == 12) ? 1 : 0);
        end
        load_valid = 1'b0;
        for (int i = 0; i < 16; i++)
            rd(4'(i), 4'((i + 1) % 16), ld_a(i), ld_a((i + 1) % 16), ld_b(i), ld_b((i + 1) % 16));

        // Write port stalls the loader for one cycle.
        load_valid = 1'b1; load_data = 8'h77;
        we = 1'b1; waddr = 4'd7; wdata = 8'hEE;
        #1;
        check("stall_ready_a", 32'(load_ready_a), 0);
        check("stall_ready_b", 32'(load_ready_b), 0);
        #1;
        cyc();
        check("stall_ptr_a", 32'(load_ptr_a), 1);
        check("stall_ptr_b", 32'(load_ptr_b), 5);
        we = 1'b0;
        #1;
        check("resume_ready_a", 32'(load_ready_a), 1);
        cyc();
        load_valid = 1'b0;
        check("resume_ptr_a", 32'(load_ptr_a), 2);
        check("resume_ptr_b", 32'(load_ptr_b), 6);
        rd(4'd7, 4'd1, 8'hEE, 8'h77, 8'hEE, 8'h0E);
        rd(4'd5, 4'd1, 8'h06, 8'h77, 8'h77, 8'h0E);

        // Asynchronous reset in the middle of a load.
        raddr = {4'd1, 4'd0};
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        load_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load_data = 8'(8'h30 + i);
            cyc();
        end
        check("midload_ptr_a", 32'(load_ptr_a), 5);
        check("midload_rdata_a", 32'(rdata_a), 32'h3130);
        #2;
        rst = 1'b1;
        #1;
        check("async_rdata_a", 32'(rdata_a), 0);
        check("async_rdata_b", 32'(rdata_b), 0);
        check("async_ptr_a", 32'(load_ptr_a), 0);
        check("async_ptr_b", 32'(load_ptr_b), 0);
        check("async_ready_a", 32'(load_ready_a), 0);
        load_valid = 1'b0;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i), 8'h00, 8'h00, 8'h00, 8'h00);

        for (int i = 0; i < 10 && sb.size() != 0; i++) cyc();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
